// File: rtl/evt_send_sched.sv
// Event-packet send scheduler: tracks events pending in the event FIFO and
// requests packet emission on threshold, latency timeout or software request.
module evt_send_sched #(
  parameter int COUNT_WIDTH   = 9,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_events,
  input  logic                     evt_recorded,
  input  logic                     sw_send_req,
  input  logic [COUNT_WIDTH-1:0]   evt_threshold,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                     evt_pkt_sent,
  input  logic [COUNT_WIDTH-1:0]   num_evts_in_pkt,
  output logic                     send_pkt,
  output logic                     sched_busy,
  output logic [COUNT_WIDTH-1:0]   pending_evts,
  output logic [1:0]               send_cause,
  output logic                     pend_overflow,
  output logic [PKT_CNT_WIDTH-1:0] num_pkts_sched,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_SENT = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMR_MAX = {TIMEOUT_WIDTH{1'b1}};
  localparam logic [TIMEOUT_WIDTH-1:0] TMR_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PKT_CNT_WIDTH-1:0] PKT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]     pending_q, pending_d, pend_sub;
  logic [TIMEOUT_WIDTH-1:0]   timer_q, timer_d;
  logic                       sw_req_q, sw_req_d;
  logic                       send_q, send_d;
  logic                       busy_q, busy_d;
  logic [1:0]                 cause_q, cause_d;
  logic                       ovf_q, ovf_d;
  logic [PKT_CNT_WIDTH-1:0]   pkts_q, pkts_d;
  logic                       pend_nz, trig_sw, trig_tmo, trig_thr, trig_any;

  always_comb begin
    pend_nz  = (pending_q != '0);
    trig_sw  = sw_req_q;
    trig_tmo = (timeout_cycles != '0) && pend_nz && (timer_q >= timeout_cycles);
    trig_thr = (evt_threshold != '0) && (pending_q >= evt_threshold);
    trig_any = enable_events && (trig_sw || trig_tmo || trig_thr);
  end

  // Decrement first (floored at 0), then add the new event (capped at all-ones).
  always_comb begin
    pend_sub = pending_q;
    if (evt_pkt_sent) begin
      pend_sub = (num_evts_in_pkt > pending_q) ? '0 : (pending_q - num_evts_in_pkt);
    end
    pending_d = pend_sub;
    if (evt_recorded && (pend_sub != CNT_MAX)) begin
      pending_d = pend_sub + CNT_ONE;
    end
    if (!enable_events) begin
      pending_d = '0;
    end
    ovf_d = ovf_q || (evt_recorded && (pending_q == CNT_MAX));
  end

  always_comb begin
    timer_d = timer_q;
    if (!enable_events || (state_q == ST_ISSUE) || !pend_nz) begin
      timer_d = '0;
    end else if ((state_q == ST_IDLE) && (timer_q != TMR_MAX)) begin
      timer_d = timer_q + TMR_ONE;
    end

    sw_req_d = sw_req_q;
    if (!enable_events) begin
      sw_req_d = 1'b0;
    end else if (sw_send_req) begin
      sw_req_d = 1'b1;
    end else if (state_q == ST_ISSUE) begin
      sw_req_d = 1'b0;
    end
  end

  // Handshake: send_pkt is a one-cycle request with no back-pressure; the
  // writer answers later with a one-cycle evt_pkt_sent carrying num_evts_in_pkt.
  always_comb begin
    state_d = state_q;
    send_d  = 1'b0;
    busy_d  = 1'b0;
    cause_d = cause_q;
    pkts_d  = pkts_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_any) begin
          state_d = ST_ISSUE;
          send_d  = 1'b1;
          busy_d  = 1'b1;
          if (trig_sw) begin
            cause_d = 2'b11;
          end else if (trig_tmo) begin
            cause_d = 2'b10;
          end else begin
            cause_d = 2'b01;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_SENT;
        busy_d  = 1'b1;
        pkts_d  = pkts_q + PKT_ONE;
      end
      ST_WAIT_SENT: begin
        if (evt_pkt_sent) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      sw_req_q  <= 1'b0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= 2'b00;
      ovf_q     <= 1'b0;
      pkts_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      sw_req_q  <= sw_req_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      ovf_q     <= ovf_d;
      pkts_q    <= pkts_d;
    end
  end

  assign send_pkt       = send_q;
  assign sched_busy     = busy_q;
  assign pending_evts   = pending_q;
  assign send_cause     = cause_q;
  assign pend_overflow  = ovf_q;
  assign num_pkts_sched = pkts_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_evt_send_sched.sv
// Self-checking bench for evt_send_sched: per-cycle vector table plus
// directed sequences for timeout, software, enable, reset and saturation.
module tb_evt_send_sched;
  localparam int CW = 9;
  localparam int TW = 24;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          en, rec, sw, sent;
  logic [CW-1:0] thr, num;
  logic [TW-1:0] tmo;
  logic          send_pkt, busy, ovf;
  logic [CW-1:0] pend;
  logic [1:0]    cause, dbg;
  logic [PW-1:0] pkts;

  logic          rec3, sent3;
  logic [2:0]    num3, pend3;
  logic          send3, busy3, ovf3;
  logic [1:0]    cause3, dbg3;
  logic [PW-1:0] pkts3;

  evt_send_sched #(.COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW), .PKT_CNT_WIDTH(PW)) u_dut (
    .clk(clk), .reset(reset), .enable_events(en), .evt_recorded(rec),
    .sw_send_req(sw), .evt_threshold(thr), .timeout_cycles(tmo),
    .evt_pkt_sent(sent), .num_evts_in_pkt(num), .send_pkt(send_pkt),
    .sched_busy(busy), .pending_evts(pend), .send_cause(cause),
    .pend_overflow(ovf), .num_pkts_sched(pkts), .dbg_state(dbg)
  );

  evt_send_sched #(.COUNT_WIDTH(3), .TIMEOUT_WIDTH(TW), .PKT_CNT_WIDTH(PW)) u_dut3 (
    .clk(clk), .reset(reset), .enable_events(1'b1), .evt_recorded(rec3),
    .sw_send_req(1'b0), .evt_threshold(3'd0), .timeout_cycles(24'd0),
    .evt_pkt_sent(sent3), .num_evts_in_pkt(num3), .send_pkt(send3),
    .sched_busy(busy3), .pending_evts(pend3), .send_cause(cause3),
    .pend_overflow(ovf3), .num_pkts_sched(pkts3), .dbg_state(dbg3)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic          rec;
    logic          sent;
    logic [CW-1:0] num;
    logic [CW-1:0] thr;
    logic          exp_send;
    logic          exp_busy;
    logic [CW-1:0] exp_pend;
    logic [1:0]    exp_cause;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input int n, input int t,
                              input logic es, input logic eb, input int ep, input int ec);
    vec_t v;
    v.rec = r; v.sent = s; v.num = CW'(n); v.thr = CW'(t);
    v.exp_send = es; v.exp_busy = eb; v.exp_pend = CW'(ep); v.exp_cause = 2'(ec);
    return v;
  endfunction

  // Inputs are applied on the falling edge; outputs are observed 1 time unit
  // after the following rising edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic [CW-1:0] n);
    @(negedge clk);
    rec = r; sw = s; sent = p; num = n;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      if (send_pkt === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  vec_t vecs[21];
  int   k;

  initial begin
    // rec, sent, num, thr | send, busy, pend, cause
    vecs[0]  = mk(1, 0, 0, 4, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 4, 0, 0, 2, 0);
    vecs[2]  = mk(1, 0, 0, 4, 0, 0, 3, 0);
    vecs[3]  = mk(1, 0, 0, 4, 0, 0, 4, 0);
    vecs[4]  = mk(0, 0, 0, 4, 1, 1, 4, 1);
    vecs[5]  = mk(0, 0, 0, 4, 0, 1, 4, 1);
    vecs[6]  = mk(0, 1, 4, 4, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 4, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 2, 1);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 3, 1);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 4, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 5, 1);
    vecs[13] = mk(1, 1, 3, 0, 0, 0, 3, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 4, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 5, 1);
    vecs[16] = mk(1, 1, 9, 0, 0, 0, 1, 1);
    vecs[17] = mk(0, 0, 0, 1, 1, 1, 1, 1);
    vecs[18] = mk(0, 0, 0, 1, 0, 1, 1, 1);
    vecs[19] = mk(0, 1, 1, 1, 0, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 1, 0, 0, 0, 1);

    // Clock/reset
    reset = 1'b1; en = 1'b1; rec = 1'b0; sw = 1'b0; sent = 1'b0;
    num = '0; thr = '0; tmo = '0; rec3 = 1'b0; sent3 = 1'b0; num3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send", 32'(send_pkt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_pkts", 32'(pkts), 0);
    chk("rst_state", 32'(dbg), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_idle", 32'(busy), 0);

    // Threshold trigger and simultaneous increment/decrement table
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      rec = vecs[i].rec; sent = vecs[i].sent; num = vecs[i].num; thr = vecs[i].thr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_send", i), 32'(send_pkt), 32'(vecs[i].exp_send));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_pend", i), 32'(pend), 32'(vecs[i].exp_pend));
      chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
    end
    chk("tbl_pkts", 32'(pkts), 2);
    chk("tbl_ovf", 32'(ovf), 0);

    // Timeout trigger, and timer restart after the packet completes
    thr = '0; tmo = TW'(10);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("tmo_pend1", 32'(pend), 1);
    wait_send(20, k);
    chk("tmo_latency", 32'(k), 11);
    chk("tmo_cause", 32'(cause), 2);
    chk("tmo_busy", 32'(busy), 1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("tmo_send_one_cycle", 32'(send_pkt), 0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("tmo_idle_after_sent", 32'(busy), 0);
    chk("tmo_pend_kept", 32'(pend), 1);
    wait_send(20, k);
    chk("tmo_timer_cleared", 32'(k), 11);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, CW'(1));
    chk("tmo_pend_zero", 32'(pend), 0);
    tmo = '0;

    // Software requests, collapsing of repeats during WAIT_SENT
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("sw_latched_no_send", 32'(send_pkt), 0);
    wait_send(5, k);
    chk("sw_latency", 32'(k), 1);
    chk("sw_cause", 32'(cause), 3);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("sw_wait_busy", 32'(busy), 1);
    chk("sw_wait_no_send", 32'(send_pkt), 0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("sw_sent_idle", 32'(busy), 0);
    wait_send(5, k);
    chk("sw_collapsed_send", 32'(k), 1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    wait_send(8, k);
    chk("sw_no_extra_send", 32'(k), -1);
    chk("sw_pkts", 32'(pkts), 6);

    // Enable low clears pending and any latched request
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    chk("en_pend6", 32'(pend), 6);
    en = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("en_low_pend", 32'(pend), 0);
    chk("en_low_send", 32'(send_pkt), 0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("en_low_pend_held", 32'(pend), 0);
    en = 1'b1;
    wait_send(8, k);
    chk("en_no_send", 32'(k), -1);

    // Asynchronous reset while waiting for the writer
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    wait_send(3, k);
    chk("rstw_send", 32'(k), 1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rstw_busy", 32'(busy), 1);
    chk("rstw_state", 32'(dbg), 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstw_send0", 32'(send_pkt), 0);
    chk("rstw_busy0", 32'(busy), 0);
    chk("rstw_pend0", 32'(pend), 0);
    chk("rstw_cause0", 32'(cause), 0);
    chk("rstw_pkts0", 32'(pkts), 0);
    chk("rstw_idle", 32'(dbg), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rstw_stays_idle", 32'(busy), 0);

    // Saturation on a 3-bit counter instance
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      rec3 = 1'b1;
      @(posedge clk);
      #1;
      if (i == 7) chk("sat_pend7_at7", 32'(pend3), 7);
      if (i == 7) chk("sat_no_ovf_at7", 32'(ovf3), 0);
      if (i == 8) chk("sat_ovf_at8", 32'(ovf3), 1);
    end
    chk("sat_pend_held", 32'(pend3), 7);
    chk("sat_no_send", 32'(send3), 0);
    @(negedge clk);
    rec3 = 1'b0; sent3 = 1'b1; num3 = 3'd2;
    @(posedge clk);
    #1;
    chk("sat_dec", 32'(pend3), 5);
    chk("sat_ovf_sticky", 32'(ovf3), 1);
    @(negedge clk);
    sent3 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
